// File: rtl/fft_dual_reorder_if.sv
// Natural-order output stream of fft_dual_reorder: each beat carries one bin of both channels.
interface fft_dual_reorder_if #(
  parameter int N          = 1024,
  parameter int DATA_WIDTH = 25
);
  localparam int N_LOG2 = $clog2(N);

  logic                         valid_o;
  logic                         ready_i;
  logic        [N_LOG2-1:0]     bin_o;
  logic                         last_o;
  logic signed [DATA_WIDTH-1:0] data1_re_o;
  logic signed [DATA_WIDTH-1:0] data1_im_o;
  logic signed [DATA_WIDTH-1:0] data2_re_o;
  logic signed [DATA_WIDTH-1:0] data2_im_o;

  modport master (
    output valid_o, bin_o, last_o, data1_re_o, data1_im_o, data2_re_o, data2_im_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, bin_o, last_o, data1_re_o, data1_im_o, data2_re_o, data2_im_o,
    output ready_i
  );
endinterface

// File: rtl/fft_dual_reorder.sv
// Reorders permuted dual-channel FFT output into natural bin order through a
// ping-pong buffer and streams completed frames over a valid/ready interface.
module fft_dual_reorder #(
  parameter int  N          = 1024,
  parameter int  DATA_WIDTH = 25,
  localparam int N_LOG2     = $clog2(N)
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         sync_i,
  input  logic        [N_LOG2-1:0]     ctr_i,
  input  logic signed [DATA_WIDTH-1:0] data1_re_i,
  input  logic signed [DATA_WIDTH-1:0] data1_im_i,
  input  logic signed [DATA_WIDTH-1:0] data2_re_i,
  input  logic signed [DATA_WIDTH-1:0] data2_im_i,
  output logic                         overflow_o,
  fft_dual_reorder_if.master           out_if
);
  localparam int                WORD_W   = 4 * DATA_WIDTH;
  localparam logic [N_LOG2-1:0] LAST_BIN = N_LOG2'(N - 1);
  localparam logic [0:0]        R_IDLE   = 1'b0;
  localparam logic [0:0]        R_RUN    = 1'b1;

  logic [WORD_W-1:0] mem [2*N];

  logic [N_LOG2-1:0] wr_cnt;
  logic              wr_bank;
  logic              frame_acc;
  logic [1:0]        full;
  logic              frame_start, frame_end, wr_en;

  logic [0:0]        rd_state;
  logic [N_LOG2-1:0] rd_addr;
  logic              rd_bank;
  logic              issue, en_p1, adv_out, rd_done;

  logic              vld_p1, last_p1, bank_p1;
  logic [N_LOG2-1:0] bin_p1;
  logic [WORD_W-1:0] word_p1;
  logic              bank_o;

  // Framing follows the sample count only; the accept decision is taken on the
  // registered full flag at the first sample and held for the whole frame.
  assign frame_start = sync_i && (wr_cnt == '0);
  assign frame_end   = sync_i && (wr_cnt == LAST_BIN);
  assign wr_en       = sync_i && (frame_start ? !full[wr_bank] : frame_acc);

  assign adv_out = !out_if.valid_o || out_if.ready_i;
  assign en_p1   = !vld_p1 || adv_out;
  assign issue   = (rd_state == R_RUN) && en_p1;
  assign rd_done = out_if.valid_o && out_if.ready_i && out_if.last_o;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      frame_acc  <= 1'b0;
      overflow_o <= 1'b0;
    end else if (sync_i) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_start) begin
        frame_acc <= !full[wr_bank];
        if (full[wr_bank]) overflow_o <= 1'b1;
      end
      if (frame_end && frame_acc) wr_bank <= ~wr_bank;
    end
  end

  // Set and clear always target different banks, so both may land in one cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (frame_end && frame_acc) full[wr_bank] <= 1'b1;
      if (rd_done)                full[bank_o]  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_bank  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: if (full[rd_bank]) begin
          rd_addr  <= '0;
          rd_state <= R_RUN;
        end
        R_RUN: if (issue) begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == LAST_BIN) begin
            rd_bank  <= ~rd_bank;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Buffer RAM: read enable follows the stall so the registered word holds.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[{wr_bank, ctr_i}] <= {data1_re_i, data1_im_i, data2_re_i, data2_im_i};
    if (issue) word_p1 <= mem[{rd_bank, rd_addr}];
  end

  // Stage p1: RAM output tags
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      bin_p1  <= '0;
      last_p1 <= 1'b0;
      bank_p1 <= 1'b0;
    end else if (en_p1) begin
      vld_p1  <= issue;
      bin_p1  <= rd_addr;
      last_p1 <= (rd_addr == LAST_BIN);
      bank_p1 <= rd_bank;
    end
  end

  // Output stage: loads only when empty or the current beat is taken
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_if.valid_o    <= 1'b0;
      out_if.bin_o      <= '0;
      out_if.last_o     <= 1'b0;
      out_if.data1_re_o <= '0;
      out_if.data1_im_o <= '0;
      out_if.data2_re_o <= '0;
      out_if.data2_im_o <= '0;
      bank_o            <= 1'b0;
    end else if (adv_out) begin
      out_if.valid_o <= vld_p1;
      if (vld_p1) begin
        out_if.bin_o      <= bin_p1;
        out_if.last_o     <= last_p1;
        out_if.data1_re_o <= $signed(word_p1[4*DATA_WIDTH-1 -: DATA_WIDTH]);
        out_if.data1_im_o <= $signed(word_p1[3*DATA_WIDTH-1 -: DATA_WIDTH]);
        out_if.data2_re_o <= $signed(word_p1[2*DATA_WIDTH-1 -: DATA_WIDTH]);
        out_if.data2_im_o <= $signed(word_p1[DATA_WIDTH-1 -: DATA_WIDTH]);
        bank_o            <= bank_p1;
      end
    end
  end
endmodule
